// File: rtl/axis_sink_pkg.sv
// Shared types and constants for the AXI4-Stream packet sink.
package axis_sink_pkg;

    // Backpressure patterns selectable on ReadyMode
    typedef enum logic [1:0] {
        ALWAYS    = 2'd0,
        ALTERNATE = 2'd1,
        RANDOM    = 2'd2,
        NEVER     = 2'd3
    } ready_mode_e;

    // Packet delimiting states
    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } sink_state_e;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
    localparam int                    LFSR_WIDTH    = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAP_MASK = 16'hB400;

    // One step of the ready-generator LFSR
    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] cur);
        return {cur[LFSR_WIDTH-2:0], ^(cur & LFSR_TAP_MASK)};
    endfunction

endpackage

// File: rtl/axis_ready_throttle.sv
// Registered TREADY pattern generator: always, alternate, pseudo-random or never.
module axis_ready_throttle
    import axis_sink_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic        Clk,
    input  logic        ResetL,
    input  ready_mode_e ready_mode,
    output logic        ready
);

    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic                  alt_phase_q;

    // The LFSR free-runs every cycle; the alternate phase restarts at 1 whenever the mode is left
    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            ready       <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            alt_phase_q <= 1'b1;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
            case (ready_mode)
                ALWAYS: begin
                    ready       <= 1'b1;
                    alt_phase_q <= 1'b1;
                end
                ALTERNATE: begin
                    ready       <= alt_phase_q;
                    alt_phase_q <= ~alt_phase_q;
                end
                RANDOM: begin
                    ready       <= lfsr_q[0];
                    alt_phase_q <= 1'b1;
                end
                default: begin
                    ready       <= 1'b0;
                    alt_phase_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/axis_packet_sink.sv
// AXI4-Stream slave sink: throttles TREADY, delimits packets on TLAST and keeps statistics.
module axis_packet_sink
    import axis_sink_pkg::*;
#(
    parameter int                    C_S_AXIS_TDATA_WIDTH = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED            = 16'hACE1
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESETN,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    input  logic [1:0]                        ReadyMode,
    input  logic [31:0]                       ExpectedPacketSize,
    input  logic                              ClearStats,
    output logic [31:0]                       TotalReceivedPacketData,
    output logic [31:0]                       TotalReceivedPackets,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   LastReceivedPacket_head,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   LastReceivedPacket_tail,
    output logic [31:0]                       LastPacketLength,
    output logic [31:0]                       LengthErrorCount
);

    sink_state_e                     state_q, state_d;
    logic [31:0]                     beat_cnt_q;
    logic [31:0]                     beat_cnt_inc;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] head_pending_q;
    logic                            beat_accept;
    logic                            pkt_done;
    logic [31:0]                     done_len;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] done_head;
    logic                            len_mismatch;
    logic                            unused_strb;

    // Byte strobes carry no meaning for this sink
    assign unused_strb = ^S_AXIS_TSTRB;

    axis_ready_throttle #(
        .LFSR_SEED (LFSR_SEED)
    ) u_throttle (
        .Clk        (S_AXIS_ACLK),
        .ResetL     (S_AXIS_ARESETN),
        .ready_mode (ready_mode_e'(ReadyMode)),
        .ready      (S_AXIS_TREADY)
    );

    assign beat_accept = S_AXIS_TVALID & S_AXIS_TREADY;
    assign pkt_done    = beat_accept & S_AXIS_TLAST;

    // Packet state register
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the length/head of a packet completing this cycle
    always_comb begin
        state_d      = state_q;
        beat_cnt_inc = (beat_cnt_q == 32'hFFFF_FFFF) ? beat_cnt_q : beat_cnt_q + 32'd1;
        done_len     = (state_q == IDLE) ? 32'd1 : beat_cnt_inc;
        done_head    = (state_q == IDLE) ? S_AXIS_TDATA : head_pending_q;
        len_mismatch = (ExpectedPacketSize != 32'd0) && (done_len != ExpectedPacketSize);
        if (ClearStats) begin
            state_d = IDLE;
        end else if (beat_accept) begin
            case (state_q)
                IDLE:    state_d = S_AXIS_TLAST ? IDLE : IN_PKT;
                IN_PKT:  state_d = S_AXIS_TLAST ? IDLE : IN_PKT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Beat/packet counters and captured words; a clear wins over a beat in the same cycle
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            beat_cnt_q              <= '0;
            head_pending_q          <= '0;
            TotalReceivedPacketData <= '0;
            TotalReceivedPackets    <= '0;
            LastReceivedPacket_head <= '0;
            LastReceivedPacket_tail <= '0;
            LastPacketLength        <= '0;
            LengthErrorCount        <= '0;
        end else if (ClearStats) begin
            beat_cnt_q              <= '0;
            head_pending_q          <= '0;
            TotalReceivedPacketData <= '0;
            TotalReceivedPackets    <= '0;
            LastReceivedPacket_head <= '0;
            LastReceivedPacket_tail <= '0;
            LastPacketLength        <= '0;
            LengthErrorCount        <= '0;
        end else if (beat_accept) begin
            TotalReceivedPacketData <= TotalReceivedPacketData + 32'd1;
            if (state_q == IDLE) begin
                head_pending_q <= S_AXIS_TDATA;
                beat_cnt_q     <= 32'd1;
            end else begin
                beat_cnt_q <= beat_cnt_inc;
            end
            if (pkt_done) begin
                LastReceivedPacket_head <= done_head;
                LastReceivedPacket_tail <= S_AXIS_TDATA;
                LastPacketLength        <= done_len;
                TotalReceivedPackets    <= TotalReceivedPackets + 32'd1;
                if (len_mismatch) begin
                    LengthErrorCount <= LengthErrorCount + 32'd1;
                end
            end
        end
    end

endmodule

// File: doc/axis_packet_sink.md
# axis_packet_sink

AXI4-Stream slave endpoint that terminates the ADC sample stream and measures it. It accepts beats under a selectable backpressure pattern, delimits packets on TLAST, and keeps packet and beat counters. It also captures the first and last data word of the most recent packet and checks each packet's length against an expected value. It sits opposite the AD7276 sampling master, in simulation benches and as an on-chip stream monitor/sink.

## Interface
Parameters:
- C_S_AXIS_TDATA_WIDTH, 32, stream data width (multiple of 8).
- LFSR_SEED, 16'hACE1, non-zero reset value of the pseudo-random ready generator.

Ports:
- S_AXIS_ACLK  in  1  single clock; all logic on its rising edge.
- S_AXIS_ARESETN  in  1  reset, asynchronous assert, active-low; release is taken synchronously on the next clock edge.
- S_AXIS_TVALID  in  1  master beat valid.
- S_AXIS_TREADY  out  1  sink ready.
- S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  beat data.
- S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  byte strobes; accepted and ignored.
- S_AXIS_TLAST  in  1  last beat of packet.
- ReadyMode  in  2  0 = always ready, 1 = alternate, 2 = pseudo-random, 3 = never ready.
- ExpectedPacketSize  in  32  expected beats per packet; 0 disables the length check.
- ClearStats  in  1  synchronous clear of all statistics.
- TotalReceivedPacketData  out  32  accepted beats, all packets.
- TotalReceivedPackets  out  32  completed packets.
- LastReceivedPacket_head  out  C_S_AXIS_TDATA_WIDTH  first word of the last completed packet.
- LastReceivedPacket_tail  out  C_S_AXIS_TDATA_WIDTH  TLAST word of the last completed packet.
- LastPacketLength  out  32  beat count of the last completed packet.
- LengthErrorCount  out  32  packets whose length was not ExpectedPacketSize (check enabled).

## Operation
- Acceptance: a beat is accepted on a rising edge when TVALID and TREADY are both high. Nothing else changes the statistics.
- TREADY generation is registered, recomputed every cycle from ReadyMode:
  - Mode 0: TREADY = 1.
  - Mode 1: TREADY toggles every cycle, starting at 1.
  - Mode 2: 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle; TREADY = lfsr[0].
  - Mode 3: TREADY = 0.
  - TREADY is independent of TVALID.
- FSM with states IDLE and IN_PKT:
  - IDLE, accepted beat, TLAST=0: capture the word as pending head, set beat count to 1, go to IN_PKT.
  - IDLE, accepted beat, TLAST=1: single-beat packet; complete with head = tail = that word, length 1.
  - IN_PKT, accepted beat: beat count +1 (saturates at all-ones). On TLAST, complete the packet and go to IDLE.
- Packet completion:
  - Update LastReceivedPacket_head, LastReceivedPacket_tail and LastPacketLength.
  - TotalReceivedPackets +1.
  - LengthErrorCount +1 if ExpectedPacketSize≠0 and length≠ExpectedPacketSize. ExpectedPacketSize is sampled at the TLAST beat.
- Every accepted beat increments TotalReceivedPacketData.
- Total counters wrap modulo 2^32.
- ClearStats has priority over a beat accepted in the same cycle:
  - All statistic outputs and the beat count go to 0 and the FSM goes to IDLE.
  - That beat is dropped from statistics; the next accepted beat starts a new packet.
  - ClearStats does not affect TREADY or the LFSR.

## Timing
- Reset values: TREADY 0, all statistic outputs 0, FSM IDLE, LFSR = LFSR_SEED, alternate phase so that the first TREADY after reset is 1.
- First edge after reset release: TREADY follows ReadyMode on the next cycle.
- A ReadyMode change takes effect on TREADY one cycle later.
- Statistics are registered and become visible one cycle after the accepting edge.
- Reset mid-packet: outputs clear immediately and the partial packet is discarded.

## Structure
- Package axis_sink_pkg holds:
  - the ready_mode_e enum (ALWAYS, ALTERNATE, RANDOM, NEVER);
  - the sink_state_e enum (IDLE, IN_PKT);
  - LFSR width and tap constants.
- One sub-module, axis_ready_throttle, produces TREADY from ReadyMode (LFSR and toggle). The top level holds the FSM and counters.

## Test plan
- Reset: hold ARESETN low 10 cycles → TREADY=0 and all statistics 0. ReadyMode=0 after release → TREADY=1 on the second edge.
- Mode 0, ExpectedPacketSize=32, 32 beats with data 0..31, TLAST on 31 → TotalReceivedPackets=1, TotalReceivedPacketData=32, head=0, tail=31, LastPacketLength=32, LengthErrorCount=0.
- ExpectedPacketSize=32, 31-beat packet, then a 1-beat packet with data 0xA5 → LengthErrorCount=2. The final packet gives head=tail=0xA5 and length 1.
- Mode 1, TVALID held high with a 76-beat packet → exactly 76 beats accepted in 152 cycles, TotalReceivedPacketData=76. Mode 3 for 50 cycles → no change.
- ClearStats pulsed on the TLAST beat of a 10-beat packet → all statistics 0 the next cycle. A following 4-beat packet yields TotalReceivedPackets=1, TotalReceivedPacketData=4.
- ARESETN asserted asynchronously at beat 5 of 20 → outputs 0 before the next edge. After release, an 8-beat packet gives head = its first word and length 8.
